// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write ports, read ports, reservation and flush.
// The master drives writes, read selects and reservations; the slave returns read data and busy flags.
interface register_file_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   wsel;
    logic [NWR*XLEN-1:0] wdat;
    logic [NRD*AW-1:0]   rsel;
    logic [NRD*XLEN-1:0] rdat;
    logic [NRD-1:0]      rbusy;
    logic                rsv_en;
    logic [AW-1:0]       rsv_sel;
    logic                flush;

    modport master (
        output wen, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
        input  rdat, rbusy
    );

    modport slave (
        input  wen, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
        output rdat, rbusy
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write-through bypass
// and a per-register pending-write scoreboard for RAW stall detection.
module register_file_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    register_file_mp_if.slave    bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]    regs_q [NREGS-1:1];
    logic [XLEN-1:0]    regs_d [NREGS-1:1];
    logic [NREGS-1:1]   busy_q;
    logic [NREGS-1:1]   busy_d;
    logic [NRD*XLEN-1:0] rdat_c;
    logic [NRD-1:0]      rbusy_c;

    // Next state: ascending port order lets the highest-index writer win;
    // reserve overrides write-clear, flush overrides everything.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < int'(NWR); p++) begin
            if (bus.wen[p]) begin
                for (int r = 1; r < int'(NREGS); r++) begin
                    if (bus.wsel[p*AW +: AW] == AW'(r)) begin
                        regs_d[r] = bus.wdat[p*XLEN +: XLEN];
                        busy_d[r] = 1'b0;
                    end
                end
            end
        end
        if (bus.rsv_en) begin
            for (int r = 1; r < int'(NREGS); r++) begin
                if (bus.rsv_sel == AW'(r)) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read; bypass is suppressed under reset so outputs read zero immediately.
    always_comb begin
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] d;
        logic            b;
        rdat_c  = '0;
        rbusy_c = '0;
        for (int j = 0; j < int'(NRD); j++) begin
            sel = bus.rsel[j*AW +: AW];
            d   = '0;
            b   = 1'b0;
            for (int r = 1; r < int'(NREGS); r++) begin
                if (sel == AW'(r)) begin
                    d = regs_q[r];
                    b = busy_q[r];
                end
            end
            if ((BYPASS != 0) && !rst && (sel != '0)) begin
                for (int p = 0; p < int'(NWR); p++) begin
                    if (bus.wen[p] && (bus.wsel[p*AW +: AW] == sel)) begin
                        d = bus.wdat[p*XLEN +: XLEN];
                        b = 1'b0;
                    end
                end
            end
            rdat_c[j*XLEN +: XLEN] = d;
            rbusy_c[j]             = b;
        end
    end

    assign bus.rdat  = rdat_c;
    assign bus.rbusy = rbusy_c;
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (2 read, 2 write ports, bypass on):
// directed scenarios with fixed expectations, then random traffic against a behavioural model.
module tb_register_file_mp;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned NRD    = 2;
    localparam int unsigned NWR    = 2;
    localparam int unsigned BYPASS = 1;
    localparam int unsigned AW     = $clog2(NREGS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    register_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string                name;
        logic [NRD*XLEN-1:0]  rd;
        logic [NRD-1:0]       rb;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Architectural view of the register file
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];

    task automatic apply(input logic r, input logic [1:0] we,
                         input int ws0, input logic [31:0] wd0,
                         input int ws1, input logic [31:0] wd1,
                         input int rs0, input int rs1,
                         input logic rv, input int rvs, input logic fl);
        rst         = r;
        bus.wen     = we;
        bus.wsel    = {AW'(ws1), AW'(ws0)};
        bus.wdat    = {wd1, wd0};
        bus.rsel    = {AW'(rs1), AW'(rs0)};
        bus.rsv_en  = rv;
        bus.rsv_sel = AW'(rvs);
        bus.flush   = fl;
    endtask

    task automatic push_fixed(input string n, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] rb);
        exp_t e;
        e.name = n;
        e.rd   = {e1, e0};
        e.rb   = rb;
        exp_q.push_back(e);
    endtask

    function automatic void model_read(input int sel, output logic [XLEN-1:0] d, output bit b);
        bit hit;
        d   = '0;
        b   = 1'b0;
        hit = 1'b0;
        if (rst || sel == 0) return;
        d = m_mem[sel];
        b = m_busy[sel];
        if (BYPASS != 0) begin
            for (int p = int'(NWR) - 1; p >= 0; p--) begin
                if (!hit && bus.wen[p] && int'(bus.wsel[p*AW +: AW]) == sel) begin
                    d   = bus.wdat[p*XLEN +: XLEN];
                    b   = 1'b0;
                    hit = 1'b1;
                end
            end
        end
    endfunction

    task automatic push_model(input string n);
        exp_t e;
        logic [XLEN-1:0] d;
        bit b;
        e.name = n;
        for (int j = 0; j < int'(NRD); j++) begin
            model_read(int'(bus.rsel[j*AW +: AW]), d, b);
            e.rd[j*XLEN +: XLEN] = d;
            e.rb[j]              = b;
        end
        exp_q.push_back(e);
    endtask

    function automatic void model_commit();
        int sel;
        if (rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
            return;
        end
        for (int p = 0; p < int'(NWR); p++) begin
            sel = int'(bus.wsel[p*AW +: AW]);
            if (bus.wen[p] && sel != 0) begin
                m_mem[sel]  = bus.wdat[p*XLEN +: XLEN];
                m_busy[sel] = 1'b0;
            end
        end
        if (bus.flush) begin
            for (int r = 0; r < int'(NREGS); r++) m_busy[r] = 1'b0;
        end else if (bus.rsv_en && bus.rsv_sel != '0) begin
            m_busy[int'(bus.rsv_sel)] = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int j = 0; j < int'(NRD); j++) begin
                    n_checks++;
                    if (bus.rdat[j*XLEN +: XLEN] === e.rd[j*XLEN +: XLEN]) n_pass++;
                    else $display("FAIL %s rdat[%0d] got %h want %h", e.name, j,
                                  bus.rdat[j*XLEN +: XLEN], e.rd[j*XLEN +: XLEN]);
                    n_checks++;
                    if (bus.rbusy[j] === e.rb[j]) n_pass++;
                    else $display("FAIL %s rbusy[%0d] got %b want %b", e.name, j,
                                  bus.rbusy[j], e.rb[j]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < int'(NREGS); r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        apply(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        push_fixed("reset", 32'h0, 32'h0, 2'b00);
        tick();

        // Reset mid-operation
        apply(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 7, 1, 7, 0);
        push_fixed("wr_x5_rsv_x7", 32'hDEADBEEF, 32'h0, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 5, 7, 0, 0, 0);
        push_fixed("pre_reset", 32'hDEADBEEF, 32'h0, 2'b10);
        tick();
        apply(1, 2'b00, 0, 0, 0, 0, 5, 7, 0, 0, 0);
        push_fixed("async_reset", 32'h0, 32'h0, 2'b00);
        tick();
        apply(1, 2'b01, 5, 32'h00001234, 0, 0, 5, 7, 1, 7, 0);
        push_fixed("reset_held_ignore", 32'h0, 32'h0, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 5, 7, 0, 0, 0);
        push_fixed("after_release", 32'h0, 32'h0, 2'b00);
        tick();

        // Basic write and x0 protection
        apply(0, 2'b11, 3, 32'h12345678, 0, 32'hFFFFFFFF, 3, 0, 0, 0, 0);
        push_fixed("wr_x3_x0_bypass", 32'h12345678, 32'h0, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        push_fixed("rd_x3_x0", 32'h12345678, 32'h0, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_fixed("rd_x0_both", 32'h0, 32'h0, 2'b00);
        tick();

        // Write-port conflict
        apply(0, 2'b11, 9, 32'hAAAA0000, 9, 32'h5555FFFF, 9, 9, 0, 0, 0);
        push_fixed("conflict_bypass", 32'h5555FFFF, 32'h5555FFFF, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 9, 3, 0, 0, 0);
        push_fixed("conflict_stored", 32'h5555FFFF, 32'h12345678, 2'b00);
        tick();

        // Bypass on read port 1
        apply(0, 2'b01, 4, 32'h00000042, 0, 0, 3, 4, 0, 0, 0);
        push_fixed("bypass_x4", 32'h12345678, 32'h42, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 4, 4, 0, 0, 0);
        push_fixed("stored_x4", 32'h42, 32'h42, 2'b00);
        tick();

        // Scoreboard lifecycle
        apply(0, 2'b00, 0, 0, 0, 0, 10, 10, 1, 10, 0);
        push_fixed("rsv_x10_same", 32'h0, 32'h0, 2'b00);
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(0, 2'b00, 0, 0, 0, 0, 10, 10, 0, 0, 0);
            push_fixed("x10_busy", 32'h0, 32'h0, 2'b11);
            tick();
        end
        apply(0, 2'b10, 0, 0, 10, 32'h77, 10, 4, 0, 0, 0);
        push_fixed("wr_x10_clear", 32'h77, 32'h42, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 10, 10, 0, 0, 0);
        push_fixed("x10_done", 32'h77, 32'h77, 2'b00);
        tick();

        // Priority: reserve beats write-clear, flush beats reserve
        apply(0, 2'b00, 0, 0, 0, 0, 11, 11, 1, 11, 0);
        push_fixed("rsv_x11", 32'h0, 32'h0, 2'b00);
        tick();
        apply(0, 2'b01, 11, 32'h5, 0, 0, 11, 11, 1, 11, 0);
        push_fixed("rsv_wr_x11", 32'h5, 32'h5, 2'b00);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 11, 12, 0, 0, 0);
        push_fixed("x11_still_busy", 32'h5, 32'h0, 2'b01);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 11, 12, 1, 12, 1);
        push_fixed("flush_rsv_x12", 32'h5, 32'h0, 2'b01);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 11, 12, 0, 0, 0);
        push_fixed("after_flush", 32'h5, 32'h0, 2'b00);
        tick();

        // Random traffic against the model; narrow index range provokes hazards
        for (int c = 0; c < 400; c++) begin
            apply(0, 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), $urandom,
                  int'($urandom_range(0, 15)), $urandom,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 31) == 0));
            push_model("random");
            tick();
        end
        apply(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain queue left %0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
